// File: rtl/contador_lotes.sv
// Bottle-to-batch counter: counts bottle pulses into boxes of PULSOS_POR_LOTE and
// completed boxes up to MAX_LOTES, with reject correction, pallet clear and wrap/saturate.
module contador_lotes #(
  parameter  int PULSOS_POR_LOTE = 12,
  parameter  int MAX_LOTES       = 9,
  parameter  int LARGURA         = 4,
  parameter  int MODO_SATURA     = 0,
  localparam int LARGURA_SUB     = $clog2(PULSOS_POR_LOTE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inc,
  input  logic                   dec,
  input  logic                   esvaziar,
  output logic [LARGURA_SUB-1:0] sub_contagem,
  output logic [LARGURA-1:0]     contagem,
  output logic                   lote_pronto,
  output logic                   cheio,
  output logic                   overflow
);

  // No handshake: inc, dec and esvaziar are single-cycle level-sampled events,
  // already synchronised and edge-detected upstream; every output is registered.
  localparam logic [LARGURA_SUB-1:0] ULTIMO_SUB = LARGURA_SUB'(PULSOS_POR_LOTE - 1);
  localparam logic [LARGURA_SUB-1:0] UM_SUB     = LARGURA_SUB'(1);
  localparam logic [LARGURA-1:0]     MAX_CONT   = LARGURA'(MAX_LOTES);
  localparam logic [LARGURA-1:0]     UM_CONT    = LARGURA'(1);

  logic [LARGURA_SUB-1:0] sub_next;
  logic [LARGURA-1:0]     cont_base, cont_next;
  logic                   ovf_base, ovf_next;
  logic                   pronto_next;
  logic                   bloqueado;

  always_comb begin
    // Pallet clear applies first; the partial box is deliberately left intact.
    cont_base   = esvaziar ? '0 : contagem;
    ovf_base    = esvaziar ? 1'b0 : overflow;
    bloqueado   = (MODO_SATURA != 0) && (cont_base == MAX_CONT);
    sub_next    = sub_contagem;
    cont_next   = cont_base;
    ovf_next    = ovf_base;
    pronto_next = 1'b0;
    if (inc && !dec) begin
      if (bloqueado) begin
        ovf_next = 1'b1;
      end else if (sub_contagem == ULTIMO_SUB) begin
        sub_next    = '0;
        pronto_next = 1'b1;
        cont_next   = (cont_base == MAX_CONT) ? '0 : cont_base + UM_CONT;
      end else begin
        sub_next = sub_contagem + UM_SUB;
      end
    end else if (dec && !inc && (sub_contagem != '0)) begin
      sub_next = sub_contagem - UM_SUB;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub_contagem <= '0;
      contagem     <= '0;
      lote_pronto  <= 1'b0;
      cheio        <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      sub_contagem <= sub_next;
      contagem     <= cont_next;
      lote_pronto  <= pronto_next;
      cheio        <= (cont_next == MAX_CONT);
      overflow     <= ovf_next;
    end
  end

endmodule

// File: tb/tb_contador_lotes.sv
// Bench for contador_lotes: a wrapping default instance and a saturating six-bottle
// instance share stimulus and are compared every cycle against an arithmetic model.
module tb_contador_lotes;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic inc = 1'b0, dec = 1'b0, esvaziar = 1'b0;

  logic [3:0] sub_a, cont_a;
  logic       pronto_a, cheio_a, ovf_a;
  logic [2:0] sub_b;
  logic [3:0] cont_b;
  logic       pronto_b, cheio_b, ovf_b;

  int checks = 0;
  int errors = 0;

  // Model parameters per instance: 0 = defaults (wrap), 1 = six bottles, saturating.
  int p_lote[2] = '{12, 6};
  int m_max[2]  = '{9, 9};
  int m_sat[2]  = '{0, 1};
  int m_sub[2], m_cnt[2];
  bit m_pr[2], m_ovf[2];

  always #5 clk = ~clk;

  contador_lotes u_dut_a (
    .clk(clk), .reset(reset), .inc(inc), .dec(dec), .esvaziar(esvaziar),
    .sub_contagem(sub_a), .contagem(cont_a), .lote_pronto(pronto_a),
    .cheio(cheio_a), .overflow(ovf_a)
  );

  contador_lotes #(.PULSOS_POR_LOTE(6), .MAX_LOTES(9), .LARGURA(4), .MODO_SATURA(1)) u_dut_b (
    .clk(clk), .reset(reset), .inc(inc), .dec(dec), .esvaziar(esvaziar),
    .sub_contagem(sub_b), .contagem(cont_b), .lote_pronto(pronto_b),
    .cheio(cheio_b), .overflow(ovf_b)
  );

  task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic modelo_zerar();
    for (int k = 0; k < 2; k++) begin
      m_sub[k] = 0; m_cnt[k] = 0; m_pr[k] = 0; m_ovf[k] = 0;
    end
  endtask

  // Bottles are tracked as one running total modulo a full pallet cycle.
  task automatic modelo_passo(input int k, input bit i, input bit d, input bit e);
    int c, garrafas;
    if (e) begin
      m_cnt[k] = 0;
      m_ovf[k] = 0;
    end
    m_pr[k] = 0;
    c = m_cnt[k];
    if (i && !d) begin
      if (m_sat[k] != 0 && c == m_max[k]) begin
        m_ovf[k] = 1;
      end else begin
        garrafas = (c * p_lote[k] + m_sub[k] + 1) % ((m_max[k] + 1) * p_lote[k]);
        m_cnt[k] = garrafas / p_lote[k];
        m_sub[k] = garrafas % p_lote[k];
        m_pr[k]  = (m_sub[k] == 0);
      end
    end else if (d && !i && m_sub[k] > 0) begin
      m_sub[k] = m_sub[k] - 1;
    end
  endtask

  task automatic comparar_todos();
    verificar("A.sub",    32'(sub_a),    32'(m_sub[0]));
    verificar("A.cont",   32'(cont_a),   32'(m_cnt[0]));
    verificar("A.pronto", 32'(pronto_a), 32'(m_pr[0]));
    verificar("A.cheio",  32'(cheio_a),  32'(m_cnt[0] == m_max[0]));
    verificar("A.ovf",    32'(ovf_a),    32'(m_ovf[0]));
    verificar("B.sub",    32'(sub_b),    32'(m_sub[1]));
    verificar("B.cont",   32'(cont_b),   32'(m_cnt[1]));
    verificar("B.pronto", 32'(pronto_b), 32'(m_pr[1]));
    verificar("B.cheio",  32'(cheio_b),  32'(m_cnt[1] == m_max[1]));
    verificar("B.ovf",    32'(ovf_b),    32'(m_ovf[1]));
  endtask

  // Called at a falling edge: drive, let one rising edge pass, then check.
  task automatic ciclo(input bit i, input bit d, input bit e);
    inc = i; dec = d; esvaziar = e;
    @(posedge clk);
    if (!reset) modelo_zerar();
    else begin
      modelo_passo(0, i, d, e);
      modelo_passo(1, i, d, e);
    end
    @(negedge clk);
    comparar_todos();
  endtask

  task automatic reset_assincrono();
    reset = 1'b0;
    #1;
    modelo_zerar();
    comparar_todos();
    ciclo(1'b1, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    modelo_zerar();
    #1;
    reset_assincrono();
    verificar("reset.sub", 32'(sub_a), 32'd0);

    // Defaults: twelve bottles complete one box.
    for (int n = 0; n < 12; n++) ciclo(1'b1, 1'b0, 1'b0);
    verificar("12inc.cont",   32'(cont_a),   32'd1);
    verificar("12inc.sub",    32'(sub_a),    32'd0);
    verificar("12inc.pronto", 32'(pronto_a), 32'd1);
    ciclo(1'b0, 1'b0, 1'b0);
    verificar("12inc.pulso1", 32'(pronto_a), 32'd0);

    // Fill on: A reaches 10 boxes and wraps; B saturates and flags overflow.
    for (int n = 0; n < 108; n++) ciclo(1'b1, 1'b0, 1'b0);
    verificar("wrap.cont",  32'(cont_a),  32'd0);
    verificar("wrap.cheio", 32'(cheio_a), 32'd0);
    verificar("wrap.ovf",   32'(ovf_a),   32'd0);
    verificar("sat.cont",   32'(cont_b),  32'd9);
    verificar("sat.cheio",  32'(cheio_b), 32'd1);
    verificar("sat.ovf",    32'(ovf_b),   32'd1);
    verificar("sat.sub",    32'(sub_b),   32'd0);

    // A to 9 boxes + 11 bottles, then clear together with a completing bottle.
    for (int n = 0; n < 119; n++) ciclo(1'b1, 1'b0, 1'b0);
    verificar("pre.cont", 32'(cont_a), 32'd9);
    verificar("pre.sub",  32'(sub_a),  32'd11);
    ciclo(1'b1, 1'b0, 1'b1);
    verificar("esv_inc.cont",   32'(cont_a),   32'd1);
    verificar("esv_inc.sub",    32'(sub_a),    32'd0);
    verificar("esv_inc.pronto", 32'(pronto_a), 32'd1);
    verificar("esv_inc.ovf_b",  32'(ovf_b),    32'd0);
    verificar("esv_inc.cont_b", 32'(cont_b),   32'd0);

    // Reject corrections stop at zero; inc with dec is a net no-op.
    for (int n = 0; n < 5; n++) ciclo(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 7; n++) ciclo(1'b0, 1'b1, 1'b0);
    verificar("dec.sub", 32'(sub_a), 32'd0);
    for (int n = 0; n < 3; n++) ciclo(1'b1, 1'b1, 1'b0);
    verificar("incdec.sub", 32'(sub_a), 32'd0);

    // Asynchronous reset mid-box with A at 3 boxes + 7 bottles.
    reset_assincrono();
    for (int n = 0; n < 43; n++) ciclo(1'b1, 1'b0, 1'b0);
    verificar("mid.cont", 32'(cont_a), 32'd3);
    verificar("mid.sub",  32'(sub_a),  32'd7);
    reset_assincrono();
    for (int n = 0; n < 12; n++) ciclo(1'b1, 1'b0, 1'b0);
    verificar("pos_reset.cont", 32'(cont_a), 32'd1);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++)
      ciclo(bit'($urandom_range(0, 4) < 3), bit'($urandom_range(0, 3) == 0),
            bit'($urandom_range(0, 39) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
